// File: rtl/accum_datapath.sv
// -----------------------------------------------------------------------------
// accum_datapath
//   Datapath of the 8-bit accumulator processor. It holds the program counter,
//   the instruction register, accumulator A and a unified instruction/data RAM
//   with a registered (1-cycle) read port. The control unit drives the strobes
//   below and reads back the opcode and the A status flags in the same cycle.
//   Instruction word: IR[DW-1:DW-3] opcode, IR[AW-1:0] address.
//
//   Handshake note: there is no valid/ready pair here. Every strobe is a
//   single-cycle level that takes effect on the next rising clk edge. Once
//   halted is set, MenWr/Aload/IRload/PCload are ignored until reset. prog_we
//   is always accepted.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   IRload              IR <= mem_q
//   JMPmux, PCload      PC <= JMPmux ? IR[AW-1:0] : PC+1 when PCload
//   Meminst             RAM address select: 0 = PC, 1 = IR[AW-1:0]
//   MenWr               write A into RAM at the selected address
//   Asel, Aload         A source: 00 ALU, 01 in_data, 10 mem_q, 11 hold
//   Sub                 ALU: 0 = A+mem_q, 1 = A-mem_q
//   Halt                sets the sticky halted flag on the next edge
//   in_data             external input data
//   prog_we/addr/data   program-load write port (wins over MenWr)
//   IR                  opcode to the control unit
//   Aeq0, Apos          A == 0, A strictly positive (two's complement)
//   A_out, PC_out       accumulator and program counter
//   halted              sticky halt flag
// -----------------------------------------------------------------------------
module accum_datapath #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IRload,
  input  logic          JMPmux,
  input  logic          PCload,
  input  logic          Meminst,
  input  logic          MenWr,
  input  logic [1:0]    Asel,
  input  logic          Aload,
  input  logic          Sub,
  input  logic          Halt,
  input  logic [DW-1:0] in_data,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [2:0]    IR,
  output logic          Aeq0,
  output logic          Apos,
  output logic [DW-1:0] A_out,
  output logic [AW-1:0] PC_out,
  output logic          halted
);

  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] mem_q;
  logic          halted_q, halted_d;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] alu_res;
  logic          mem_we;

  assign mem_addr = Meminst ? ir_q[AW-1:0] : pc_q;
  assign alu_res  = Sub ? (a_q - mem_q) : (a_q + mem_q);
  assign mem_we   = MenWr && !halted_q;

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    halted_d = halted_q | Halt;
    if (!halted_q) begin
      // On a fetch (IRload and PCload together) the increment uses the
      // current PC while IR captures the word read from it last cycle.
      if (PCload) pc_d = JMPmux ? ir_q[AW-1:0] : (pc_q + AW'(1));
      if (IRload) ir_d = mem_q;
      if (Aload) begin
        unique case (Asel)
          2'b00:   a_d = alu_res;
          2'b01:   a_d = in_data;
          2'b10:   a_d = mem_q;
          default: a_d = a_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      mem_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      halted_q <= halted_d;
      // Registered read: a same-cycle write to this address is not yet
      // visible, so the old contents are returned.
      mem_q    <= mem[mem_addr];
    end
  end

  // RAM contents survive reset. The program-load write is issued last so
  // that on an address collision it overrides the MenWr store.
  always_ff @(posedge clk) begin
    if (mem_we)  mem[mem_addr]  <= a_q;
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  assign IR     = ir_q[DW-1:DW-3];
  assign Aeq0   = (a_q == '0);
  assign Apos   = (a_q != '0) && !a_q[DW-1];
  assign A_out  = a_q;
  assign PC_out = pc_q;
  assign halted = halted_q;

endmodule
